reg_file_write_arbiter: RTL

- Round-robin arbiter that shares the single write port of the register file between NUM_REQ writeback requesters (ALU, load unit, etc.).
- Accepts valid/ready write requests and registers the winning address and data into a one-stage output.
- Drives the register file's write_ctrl, write_addr and write_data directly.
- Optionally suppresses writes to register 0 (hardwired-zero register) and counts suppressed writes.

---
 rtl/reg_file_write_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/reg_file_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback
// requesters, with a one-stage registered write and optional register-0 protection.
module reg_file_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int PROTECT_ZERO = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            stall,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rf_write_ctrl,
    output logic [ADDR_WIDTH-1:0]           rf_write_addr,
    output logic [DATA_WIDTH-1:0]           rf_write_data,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic [CNT_WIDTH-1:0]            dropped_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
        return (w == IDX_W'(NUM_REQ - 1)) ? '0 : w + IDX_W'(1);
    endfunction

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      cand_idx;
    logic [IDX_W-1:0]      win_idx_p0;
    logic                  vld_p0;
    logic [ADDR_WIDTH-1:0] win_addr_p0;
    logic [DATA_WIDTH-1:0] win_data_p0;
    logic                  suppress_p0;

    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [IDX_W-1:0]      gid_p1;
    logic [CNT_WIDTH-1:0]  drop_cnt;

    // Stage p0: rotating priority scan from rr_ptr; grant never looks at addr/data
    always_comb begin
        win_idx_p0 = '0;
        vld_p0     = 1'b0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!vld_p0 && req_valid[cand_idx]) begin
                vld_p0     = 1'b1;
                win_idx_p0 = cand_idx;
            end
        end
        if (stall || !reset_n) begin
            vld_p0 = 1'b0;
        end

        req_ready   = '0;
        win_addr_p0 = '0;
        win_data_p0 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == win_idx_p0) begin
                req_ready[k] = vld_p0;
                win_addr_p0  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                win_data_p0  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        suppress_p0 = (PROTECT_ZERO != 0) && (win_addr_p0 == '0);
    end

    // Stage p1: registered write; a suppressed write still updates addr/data/id
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            data_p1  <= '0;
            gid_p1   <= '0;
            drop_cnt <= '0;
        end else begin
            vld_p1 <= vld_p0 && !suppress_p0;
            if (vld_p0) begin
                rr_ptr  <= next_ptr(win_idx_p0);
                addr_p1 <= win_addr_p0;
                data_p1 <= win_data_p0;
                gid_p1  <= win_idx_p0;
                if (suppress_p0) begin
                    drop_cnt <= sat_inc(drop_cnt);
                end
            end
        end
    end

    assign rf_write_ctrl = vld_p1;
    assign rf_write_addr = addr_p1;
    assign rf_write_data = data_p1;
    assign grant_id      = gid_p1;
    assign dropped_count = drop_cnt;

endmodule
